// File: rtl/mic1_mem_serdes_if.sv
// Bundles the core request/response handshake and the pad-side beat bus
// of the MIC-1 memory serdes; slave is the serdes view, master the environment.
interface mic1_mem_serdes_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BUS_W  = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_byte;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [BUS_W-1:0]  ext_out;
    logic              ext_oe;
    logic [1:0]        ext_phase;
    logic              ext_valid;
    logic              ext_ack;
    logic [BUS_W-1:0]  ext_in;

    modport slave (
        input  req_valid, req_we, req_byte, req_addr, req_wdata, rsp_ready, ext_ack, ext_in,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, ext_out, ext_oe, ext_phase, ext_valid
    );

    modport master (
        output req_valid, req_we, req_byte, req_addr, req_wdata, rsp_ready, ext_ack, ext_in,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, ext_out, ext_oe, ext_phase, ext_valid
    );
endinterface

// File: rtl/mic1_mem_serdes.sv
// MIC-1 bus interface unit: serialises one MAR/MDR request into BUS_W-wide
// address and data beats with per-beat ack, wait states and a beat timeout.
module mic1_mem_serdes #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned BUS_W   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    mic1_mem_serdes_if.slave  bus
);
    localparam int unsigned AB     = ADDR_W / BUS_W;
    localparam int unsigned DB     = DATA_W / BUS_W;
    localparam int unsigned NB_MAX = (AB > DB) ? AB : DB;
    localparam int unsigned BEAT_W = (NB_MAX > 1) ? $clog2(NB_MAX) : 1;
    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [BEAT_W-1:0] AB_LAST = BEAT_W'(AB - 1);
    localparam logic [BEAT_W-1:0] DB_LAST = BEAT_W'(DB - 1);
    localparam logic [CNT_W-1:0]  CNT_LIM = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_RESP
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [BEAT_W-1:0] r_beat,  w_beat_nxt;
    logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic              r_we,    w_we_nxt;
    logic              r_byte,  w_byte_nxt;
    logic              r_err,   w_err_nxt;
    logic              w_in_beat;
    logic              w_last_data;
    logic              w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_we    <= 1'b0;
            r_byte  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_rdata <= w_rdata_nxt;
            r_we    <= w_we_nxt;
            r_byte  <= w_byte_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_beat_nxt    = r_beat;
        w_cnt_nxt     = r_cnt;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_rdata_nxt   = r_rdata;
        w_we_nxt      = r_we;
        w_byte_nxt    = r_byte;
        w_err_nxt     = r_err;
        w_in_beat     = 1'b0;
        w_last_data   = r_byte || (r_beat == DB_LAST);
        w_timeout     = (TIMEOUT != 0) && (r_cnt == CNT_LIM);
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        bus.ext_out   = '0;
        bus.ext_oe    = 1'b0;
        bus.ext_phase = 2'b00;
        bus.ext_valid = 1'b0;

        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_addr_nxt  = bus.req_addr;
                    w_wdata_nxt = bus.req_wdata;
                    w_we_nxt    = bus.req_we;
                    w_byte_nxt  = bus.req_byte;
                    w_beat_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_rdata_nxt = '0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                w_in_beat     = 1'b1;
                bus.ext_valid = 1'b1;
                bus.ext_oe    = 1'b1;
                bus.ext_phase = 2'b01;
                bus.ext_out   = r_addr[r_beat*BUS_W +: BUS_W];
                if (bus.ext_ack) begin
                    if (r_beat == AB_LAST) begin
                        w_beat_nxt  = '0;
                        w_state_nxt = r_we ? S_WDATA : S_RDATA;
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                end
            end
            S_WDATA: begin
                w_in_beat     = 1'b1;
                bus.ext_valid = 1'b1;
                bus.ext_oe    = 1'b1;
                bus.ext_phase = 2'b10;
                bus.ext_out   = r_wdata[r_beat*BUS_W +: BUS_W];
                if (bus.ext_ack) begin
                    if (w_last_data) w_state_nxt = S_RESP;
                    else             w_beat_nxt  = r_beat + 1'b1;
                end
            end
            S_RDATA: begin
                w_in_beat     = 1'b1;
                bus.ext_valid = 1'b1;
                bus.ext_phase = 2'b11;
                if (bus.ext_ack) begin
                    w_rdata_nxt[r_beat*BUS_W +: BUS_W] = bus.ext_in;
                    if (w_last_data) w_state_nxt = S_RESP;
                    else             w_beat_nxt  = r_beat + 1'b1;
                end
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_rdata = r_rdata;
                bus.rsp_err   = r_err;
                if (bus.rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Shared beat timer: an ack on the limit cycle is handled above and wins.
        if (w_in_beat) begin
            if (bus.ext_ack) begin
                w_cnt_nxt = '0;
            end else if (w_timeout) begin
                w_state_nxt = S_RESP;
                w_err_nxt   = 1'b1;
                w_rdata_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mic1_mem_serdes.sv
// Self-checking bench for mic1_mem_serdes (32/8 config, beat timeout of 4)
// driving the pad side as a responder and comparing against a transfer model.
module tb_mic1_mem_serdes;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 8;
    localparam int TO = 4;
    localparam int AB = AW / BW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mic1_mem_serdes_if #(.ADDR_W(AW), .DATA_W(DW), .BUS_W(BW)) bus ();

    mic1_mem_serdes #(.ADDR_W(AW), .DATA_W(DW), .BUS_W(BW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks;
    int n_errors;

    logic [7:0]  drv_in [4];
    logic [1:0]  ob_phase [$];
    logic [7:0]  ob_out [$];
    int          ob_held [$];
    int          ob_lat, ob_unstable, ob_oe_bad, ob_idle_bad, ob_hold_bad;
    logic [31:0] ob_rdata;
    logic        ob_err;

    logic [1:0]  ex_phase [$];
    logic [7:0]  ex_out [$];
    int          ex_held [$];
    int          ex_lat;
    logic [31:0] ex_rdata;
    logic        ex_err;

    // Expected beat sequence, latency and result of one transfer from the protocol rules.
    task automatic model_xfer(input logic we, input logic byt, input logic [31:0] addr,
                              input logic [31:0] wdata, input int wait_cyc,
                              input int sp_beat, input int sp_wait);
        int nd, w;
        logic [31:0] a, d;
        ex_phase.delete(); ex_out.delete(); ex_held.delete();
        nd = byt ? 1 : DW / BW;
        ex_lat = 0; ex_rdata = '0; ex_err = 1'b0;
        a = addr; d = wdata;
        for (int i = 0; i < AB + nd; i++) begin
            w = (i == sp_beat) ? sp_wait : wait_cyc;
            if (w > TO) begin
                ex_lat += TO + 1; ex_err = 1'b1; ex_rdata = '0;
                return;
            end
            ex_lat += w + 1;
            ex_held.push_back(w + 1);
            if (i < AB) begin
                ex_phase.push_back(2'b01); ex_out.push_back(a[7:0]); a = a >> 8;
            end else if (we) begin
                ex_phase.push_back(2'b10); ex_out.push_back(d[7:0]); d = d >> 8;
            end else begin
                ex_phase.push_back(2'b11); ex_out.push_back(8'h00);
                ex_rdata = ex_rdata | (32'(drv_in[i-AB]) << (8 * (i - AB)));
            end
        end
    endtask

    // Issues one request and plays the pad responder; records what the DUT did.
    task automatic run_xfer(input logic we, input logic byt, input logic [31:0] addr,
                            input logic [31:0] wdata, input int wait_cyc,
                            input int sp_beat, input int sp_wait, input int rsp_hold);
        int cw, bi, w;
        logic [7:0] f_out;
        logic [1:0] f_ph;
        logic done;
        ob_phase.delete(); ob_out.delete(); ob_held.delete();
        ob_lat = -1; ob_unstable = 0; ob_oe_bad = 0; ob_idle_bad = 0; ob_hold_bad = 0;
        ob_rdata = 'x; ob_err = 1'bx;
        cw = 0; bi = 0; done = 1'b0; f_out = '0; f_ph = '0;
        bus.req_we = we; bus.req_byte = byt; bus.req_addr = addr; bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr = $urandom; bus.req_wdata = $urandom;
        for (int k = 1; k <= 200 && !done; k++) begin
            bus.ext_ack = 1'b0;
            bus.ext_in = 8'($urandom);
            bus.rsp_ready = 1'($urandom);
            if (bus.ext_valid) begin
                if (cw == 0) begin
                    f_out = bus.ext_out; f_ph = bus.ext_phase;
                end else if (bus.ext_out !== f_out || bus.ext_phase !== f_ph) begin
                    ob_unstable++;
                end
                if (bus.ext_oe !== (f_ph == 2'b01 || f_ph == 2'b10)) ob_oe_bad++;
                w = (bi == sp_beat) ? sp_wait : wait_cyc;
                if (bus.ext_phase == 2'b11 && bi >= AB && bi < AB + 4) bus.ext_in = drv_in[bi-AB];
                if (cw >= w) begin
                    bus.ext_ack = 1'b1;
                    ob_phase.push_back(f_ph); ob_out.push_back(f_out); ob_held.push_back(cw + 1);
                    bi++; cw = 0;
                end else begin
                    cw++;
                end
            end else begin
                if (bus.ext_out !== 8'h00 || bus.ext_oe !== 1'b0 || bus.ext_phase !== 2'b00) ob_idle_bad++;
                bus.ext_ack = 1'($urandom);
            end
            @(posedge clk); #1;
            if (bus.rsp_valid) begin
                ob_lat = k; done = 1'b1;
            end
        end
        bus.ext_ack = 1'b0;
        bus.rsp_ready = 1'b0;
        if (done) begin
            ob_rdata = bus.rsp_rdata; ob_err = bus.rsp_err;
            for (int h = 0; h < rsp_hold; h++) begin
                bus.req_valid = 1'b1; bus.req_addr = $urandom;
                bus.ext_ack = 1'($urandom);
                @(posedge clk); #1;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== ob_rdata || bus.rsp_err !== ob_err ||
                    bus.req_ready !== 1'b0 || bus.ext_valid !== 1'b0) ob_hold_bad++;
            end
            bus.ext_ack = 1'b0;
            bus.rsp_ready = 1'b1;
            @(posedge clk); #1;
            bus.rsp_ready = 1'b0; bus.req_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.ext_out, bus.ext_oe,
             bus.ext_phase, bus.ext_valid} !== {1'b1, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0, 2'b00, 1'b0}) begin
            n_errors++; $display("FAIL reset_async: req_ready=%b rsp_valid=%b ext_valid=%b ext_phase=%b, want 1/0/0/00",
                                 bus.req_ready, bus.rsp_valid, bus.ext_valid, bus.ext_phase);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.ext_valid} !== 3'b100) begin
            n_errors++; $display("FAIL reset_release: req_ready/rsp_valid/ext_valid=%b want 100",
                                 {bus.req_ready, bus.rsp_valid, bus.ext_valid});
        end
    endtask

    task automatic test_word_read();
        drv_in[0] = 8'hEF; drv_in[1] = 8'hBE; drv_in[2] = 8'hAD; drv_in[3] = 8'hDE;
        model_xfer(1'b0, 1'b0, 32'h12345678, 32'h0, 0, -1, 0);
        run_xfer(1'b0, 1'b0, 32'h12345678, 32'h0, 0, -1, 0, 0);
        for (int j = 0; j < AB; j++) begin
            n_checks++;
            if (j >= ob_out.size() || ob_out[j] !== ex_out[j] || ob_phase[j] !== 2'b01) begin
                n_errors++; $display("FAIL word_read_addr_beat%0d: got %h want %h", j,
                                     (j < ob_out.size()) ? ob_out[j] : 8'hxx, ex_out[j]);
            end
        end
        n_checks++;
        if (ob_rdata !== 32'hDEADBEEF || ob_err !== 1'b0) begin
            n_errors++; $display("FAIL word_read_data: rdata=%h err=%b want deadbeef/0", ob_rdata, ob_err);
        end
        n_checks++;
        if (ob_lat !== 8) begin
            n_errors++; $display("FAIL word_read_latency: got %0d cycles want 8", ob_lat);
        end
        n_checks++;
        if (ob_idle_bad !== 0 || ob_unstable !== 0 || ob_oe_bad !== 0) begin
            n_errors++; $display("FAIL word_read_pads: idle_bad=%0d unstable=%0d oe_bad=%0d want 0",
                                 ob_idle_bad, ob_unstable, ob_oe_bad);
        end
    endtask

    task automatic test_word_write();
        model_xfer(1'b1, 1'b0, 32'h00000010, 32'hCAFEF00D, 2, -1, 0);
        run_xfer(1'b1, 1'b0, 32'h00000010, 32'hCAFEF00D, 2, -1, 0, 0);
        n_checks++;
        if (ob_phase.size() !== ex_phase.size()) begin
            n_errors++; $display("FAIL word_write_beats: got %0d want %0d", ob_phase.size(), ex_phase.size());
        end
        for (int j = 0; j < ex_phase.size() && j < ob_phase.size(); j++) begin
            n_checks++;
            if ({ob_phase[j], ob_out[j], ob_held[j]} !== {ex_phase[j], ex_out[j], ex_held[j]}) begin
                n_errors++; $display("FAIL word_write_beat%0d: ph=%b out=%h held=%0d want ph=%b out=%h held=%0d",
                                     j, ob_phase[j], ob_out[j], ob_held[j], ex_phase[j], ex_out[j], ex_held[j]);
            end
        end
        n_checks++;
        if (ob_oe_bad !== 0 || ob_unstable !== 0) begin
            n_errors++; $display("FAIL word_write_oe_hold: oe_bad=%0d unstable=%0d want 0", ob_oe_bad, ob_unstable);
        end
        n_checks++;
        if (ob_rdata !== 32'h0 || ob_err !== 1'b0 || ob_lat !== ex_lat) begin
            n_errors++; $display("FAIL word_write_rsp: rdata=%h err=%b lat=%0d want 0/0/%0d",
                                 ob_rdata, ob_err, ob_lat, ex_lat);
        end
    endtask

    task automatic test_byte_read();
        int nrd;
        drv_in[0] = 8'hA5; drv_in[1] = 8'h11; drv_in[2] = 8'h22; drv_in[3] = 8'h33;
        run_xfer(1'b0, 1'b1, 32'h00000004, 32'hFFFFFFFF, 0, -1, 0, 0);
        nrd = 0;
        foreach (ob_phase[j]) if (ob_phase[j] == 2'b11) nrd++;
        n_checks++;
        if (nrd !== 1) begin
            n_errors++; $display("FAIL byte_read_beats: got %0d rdata beats want 1", nrd);
        end
        n_checks++;
        if (ob_rdata !== 32'h000000A5 || ob_err !== 1'b0) begin
            n_errors++; $display("FAIL byte_read_data: rdata=%h err=%b want 000000a5/0", ob_rdata, ob_err);
        end
        n_checks++;
        if (ob_lat !== 5) begin
            n_errors++; $display("FAIL byte_read_latency: got %0d cycles want 5", ob_lat);
        end
    endtask

    task automatic test_timeout();
        for (int j = 0; j < 4; j++) drv_in[j] = 8'($urandom);
        model_xfer(1'b1, 1'b0, 32'h0000ABCD, 32'h12345678, 0, 1, TO + 1);
        run_xfer(1'b1, 1'b0, 32'h0000ABCD, 32'h12345678, 0, 1, TO + 1, 0);
        n_checks++;
        if (ob_err !== 1'b1 || ob_rdata !== 32'h0) begin
            n_errors++; $display("FAIL timeout_err: err=%b rdata=%h want 1/0", ob_err, ob_rdata);
        end
        n_checks++;
        if (ob_phase.size() !== 1 || ob_lat !== ex_lat) begin
            n_errors++; $display("FAIL timeout_beats: beats=%0d lat=%0d want 1/%0d", ob_phase.size(), ob_lat, ex_lat);
        end
        model_xfer(1'b0, 1'b0, 32'h0000ABCD, 32'h0, 0, 1, TO);
        run_xfer(1'b0, 1'b0, 32'h0000ABCD, 32'h0, 0, 1, TO, 0);
        n_checks++;
        if (ob_err !== 1'b0 || ob_rdata !== ex_rdata || ob_lat !== ex_lat) begin
            n_errors++; $display("FAIL timeout_ack_on_limit: err=%b rdata=%h lat=%0d want 0/%h/%0d",
                                 ob_err, ob_rdata, ob_lat, ex_rdata, ex_lat);
        end
    endtask

    task automatic test_rsp_hold();
        for (int j = 0; j < 4; j++) drv_in[j] = 8'($urandom);
        model_xfer(1'b0, 1'b0, 32'h00000020, 32'h0, 1, -1, 0);
        run_xfer(1'b0, 1'b0, 32'h00000020, 32'h0, 1, -1, 0, 5);
        n_checks++;
        if (ob_hold_bad !== 0 || ob_rdata !== ex_rdata) begin
            n_errors++; $display("FAIL rsp_hold: unstable_cycles=%0d rdata=%h want 0/%h", ob_hold_bad, ob_rdata, ex_rdata);
        end
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.ext_valid !== 1'b0) begin
            n_errors++; $display("FAIL rsp_hold_no_accept: req_ready=%b ext_valid=%b want 1/0", bus.req_ready, bus.ext_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.req_we = 1'b0; bus.req_byte = 1'b0; bus.req_addr = 32'h00000100;
        bus.req_valid = 1'b1; bus.ext_ack = 1'b1; bus.ext_in = 8'h5A;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (bus.ext_phase !== 2'b11 || bus.ext_valid !== 1'b1) begin
            n_errors++; $display("FAIL reset_mid_setup: phase=%b valid=%b want 11/1", bus.ext_phase, bus.ext_valid);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.ext_out, bus.ext_oe,
             bus.ext_phase, bus.ext_valid} !== {1'b1, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0, 2'b00, 1'b0}) begin
            n_errors++; $display("FAIL reset_mid_outputs: req_ready=%b rsp_valid=%b ext_valid=%b phase=%b want 1/0/0/00",
                                 bus.req_ready, bus.rsp_valid, bus.ext_valid, bus.ext_phase);
        end
        bus.ext_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int j = 0; j < 4; j++) drv_in[j] = 8'($urandom);
        model_xfer(1'b0, 1'b0, 32'h87654321, 32'h0, 0, -1, 0);
        run_xfer(1'b0, 1'b0, 32'h87654321, 32'h0, 0, -1, 0, 0);
        n_checks++;
        if (ob_rdata !== ex_rdata || ob_err !== 1'b0 || ob_lat !== ex_lat) begin
            n_errors++; $display("FAIL reset_mid_recover: rdata=%h err=%b lat=%0d want %h/0/%0d",
                                 ob_rdata, ob_err, ob_lat, ex_rdata, ex_lat);
        end
    endtask

    task automatic test_random();
        logic we, byt;
        logic [31:0] addr, wdata;
        int wc, sp, spw, hold;
        for (int it = 0; it < 24; it++) begin
            we = 1'($urandom); byt = 1'($urandom);
            addr = $urandom; wdata = $urandom;
            wc = $urandom_range(0, 2); sp = -1; spw = 0;
            hold = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) begin
                sp = $urandom_range(0, 7); spw = $urandom_range(3, 6);
            end
            for (int j = 0; j < 4; j++) drv_in[j] = 8'($urandom);
            model_xfer(we, byt, addr, wdata, wc, sp, spw);
            run_xfer(we, byt, addr, wdata, wc, sp, spw, hold);
            n_checks++;
            if (ob_phase.size() !== ex_phase.size()) begin
                n_errors++; $display("FAIL rand%0d_beats: got %0d want %0d", it, ob_phase.size(), ex_phase.size());
            end
            for (int j = 0; j < ex_phase.size() && j < ob_phase.size(); j++) begin
                n_checks++;
                if ({ob_phase[j], ob_out[j], ob_held[j]} !== {ex_phase[j], ex_out[j], ex_held[j]}) begin
                    n_errors++; $display("FAIL rand%0d_beat%0d: ph=%b out=%h held=%0d want ph=%b out=%h held=%0d",
                                         it, j, ob_phase[j], ob_out[j], ob_held[j], ex_phase[j], ex_out[j], ex_held[j]);
                end
            end
            n_checks++;
            if (ob_rdata !== ex_rdata || ob_err !== ex_err || ob_lat !== ex_lat) begin
                n_errors++; $display("FAIL rand%0d_rsp: rdata=%h err=%b lat=%0d want %h/%b/%0d",
                                     it, ob_rdata, ob_err, ob_lat, ex_rdata, ex_err, ex_lat);
            end
            n_checks++;
            if (ob_unstable !== 0 || ob_oe_bad !== 0 || ob_idle_bad !== 0 || ob_hold_bad !== 0) begin
                n_errors++; $display("FAIL rand%0d_pads: unstable=%0d oe_bad=%0d idle_bad=%0d hold_bad=%0d want 0",
                                     it, ob_unstable, ob_oe_bad, ob_idle_bad, ob_hold_bad);
            end
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_byte = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
        bus.ext_ack = 1'b0; bus.ext_in = '0;
        test_reset();
        test_word_read();
        test_word_write();
        test_byte_read();
        test_timeout();
        test_rsp_hold();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
